// File: rtl/ring_switch_alloc.sv
// Ring NoC switch allocator: per-output round-robin arbitration, wormhole lock until tail, one-entry output register.
// Latency: head request in cycle t -> in_ready in t+1 -> out_valid in t+2; body flits 1/cycle/output.
// Backpressure: in_ready[owner] = !out_valid | out_ready; losers and illegal requesters see in_ready = 0.
module ring_switch_alloc #(
    parameter int FLIT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            in_valid,
    input  logic [3*FLIT_W-1:0]   in_flit,
    input  logic [2:0]            in_tail,
    input  logic [5:0]            in_port,
    output logic [2:0]            in_ready,
    output logic [2:0]            out_valid,
    output logic [3*FLIT_W-1:0]   out_flit,
    output logic [2:0]            out_tail,
    input  logic [2:0]            out_ready,
    output logic                  err_bad_port
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic [2:0] locked;
    logic [1:0] owner_w [3];
    logic [2:0] grant_open;
    logic [2:0] owns;
    logic [2:0] legal;
    logic [1:0] route   [3];
    logic [2:0] bad;
    logic       err_q;

    function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // First requester found scanning upward from rr, wrapping mod 3.
    function automatic logic [1:0] rr_pick(input logic [1:0] rr, input logic [2:0] r);
        logic [1:0] c;
        logic [1:0] pick;
        pick = rr;
        for (int k = 2; k >= 0; k--) begin
            c = add3(rr, 2'(k));
            if (r[c]) begin
                pick = c;
            end
        end
        return pick;
    endfunction

    always_comb begin
        owns     = '0;
        in_ready = '0;
        legal    = '0;
        for (int i = 0; i < 3; i++) begin
            route[i] = in_port[2*i +: 2];
            // 11 is never a port; west/east inputs may not turn back the way they came.
            legal[i] = (route[i] != 2'b11)
                    && !((i == 1) && (route[i] == 2'd1))
                    && !((i == 2) && (route[i] == 2'd2));
            for (int o = 0; o < 3; o++) begin
                if (locked[o] && (owner_w[o] == 2'(i))) begin
                    owns[i]     = 1'b1;
                    in_ready[i] = grant_open[o];
                end
            end
        end
    end

    assign bad          = in_valid & ~owns & ~legal;
    assign err_bad_port = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (|bad) begin
            err_q <= 1'b1;
        end
    end

    for (genvar o = 0; o < 3; o++) begin : g_out
        state_t            state_q;
        state_t            state_d;
        logic [1:0]        owner_q;
        logic [1:0]        owner_d;
        logic [1:0]        rr_q;
        logic [1:0]        rr_d;
        logic [2:0]        req;
        logic              load;
        logic              open;
        logic [FLIT_W-1:0] sel_flit;
        logic              sel_tail;
        logic              sel_valid;
        logic              vld_q;
        logic              tail_q;
        logic [FLIT_W-1:0] flit_q;

        // Body flits follow the owner; route codes are only looked at for heads.
        always_comb begin
            req       = '0;
            sel_flit  = '0;
            sel_tail  = 1'b0;
            sel_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                req[i] = in_valid[i] && !owns[i] && legal[i] && (route[i] == 2'(o));
                if (owner_q == 2'(i)) begin
                    sel_flit  = in_flit[i*FLIT_W +: FLIT_W];
                    sel_tail  = in_tail[i];
                    sel_valid = in_valid[i];
                end
            end
        end

        assign open = (state_q == LOCKED) && (!vld_q || out_ready[o]);
        assign load = open && sel_valid;

        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            rr_d    = rr_q;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        owner_d = rr_pick(rr_q, req);
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (load && sel_tail) begin
                        state_d = IDLE;
                        rr_d    = add3(owner_q, 2'd1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                owner_q <= 2'd0;
                rr_q    <= 2'd0;
                vld_q   <= 1'b0;
                tail_q  <= 1'b0;
                flit_q  <= '0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                rr_q    <= rr_d;
                if (load) begin
                    vld_q  <= 1'b1;
                    tail_q <= sel_tail;
                    flit_q <= sel_flit;
                end else if (out_ready[o]) begin
                    vld_q  <= 1'b0;
                end
            end
        end

        assign locked[o]                   = (state_q == LOCKED);
        assign owner_w[o]                  = owner_q;
        assign grant_open[o]               = open;
        assign out_valid[o]                = vld_q;
        assign out_tail[o]                 = tail_q;
        assign out_flit[o*FLIT_W +: FLIT_W] = flit_q;
    end

endmodule

// File: tb/tb_ring_switch_alloc.sv
// Directed bench for ring_switch_alloc: hand-computed expectations for latency, arbitration, backpressure, errors and reset.
module tb_ring_switch_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid;
    logic [47:0] in_flit;
    logic [2:0]  in_tail;
    logic [5:0]  in_port;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [47:0] out_flit;
    logic [2:0]  out_tail;
    logic [2:0]  out_ready;
    logic        err_bad_port;

    int checks = 0;
    int errors = 0;

    ring_switch_alloc #(.FLIT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_flit      (in_flit),
        .in_tail      (in_tail),
        .in_port      (in_port),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_tail     (out_tail),
        .out_ready    (out_ready),
        .err_bad_port (err_bad_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_in(input int i, input logic v, input logic [15:0] f, input logic t, input logic [1:0] p);
        in_valid[i]         = v;
        in_flit[i*16 +: 16] = f;
        in_tail[i]          = t;
        in_port[2*i +: 2]   = p;
    endtask

    task automatic idle_in();
        in_valid = '0;
        in_flit  = '0;
        in_tail  = '0;
        in_port  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 3'b111;
        idle_in();

        // Reset with random inputs for two cycles
        in_valid  = 3'($urandom_range(0, 7));
        in_flit   = {16'($urandom), 16'($urandom), 16'($urandom)};
        in_tail   = 3'($urandom_range(0, 7));
        in_port   = 6'($urandom_range(0, 63));
        out_ready = 3'($urandom_range(0, 7));
        next_cycle();
        in_valid  = 3'($urandom_range(0, 7));
        in_port   = 6'($urandom_range(0, 63));
        next_cycle();
        rst = 1'b0;
        idle_in();
        out_ready = 3'b111;
        settle();
        chk("rst_out_valid", out_valid, 3'b000);
        chk("rst_in_ready", in_ready, 3'b000);
        chk("rst_err", err_bad_port, 1'b0);
        chk("rst_out_tail", out_tail, 3'b000);

        // Single 3-flit packet local -> east
        set_in(0, 1'b1, 16'hA001, 1'b0, 2'b10); settle();
        chk("sp_rdy_t", in_ready, 3'b000);
        next_cycle(); settle();
        chk("sp_rdy_t1", in_ready, 3'b001);
        chk("sp_ov_t1", out_valid, 3'b000);
        next_cycle(); set_in(0, 1'b1, 16'hA002, 1'b0, 2'b10); settle();
        chk("sp_ov_t2", out_valid, 3'b100);
        chk("sp_flit_t2", out_flit[47:32], 16'hA001);
        chk("sp_tail_t2", out_tail, 3'b000);
        chk("sp_rdy_t2", in_ready, 3'b001);
        next_cycle(); set_in(0, 1'b1, 16'hA003, 1'b1, 2'b10); settle();
        chk("sp_flit_t3", out_flit[47:32], 16'hA002);
        chk("sp_tail_t3", out_tail, 3'b000);
        chk("sp_rdy_t3", in_ready, 3'b001);
        next_cycle(); idle_in(); settle();
        chk("sp_ov_t4", out_valid, 3'b100);
        chk("sp_flit_t4", out_flit[47:32], 16'hA003);
        chk("sp_tail_t4", out_tail, 3'b100);
        chk("sp_rdy_t4", in_ready, 3'b000);
        next_cycle(); settle();
        chk("sp_ov_t5", out_valid, 3'b000);

        // Contention on east: inputs 0 and 1, rr starts at 0
        do_reset();
        set_in(0, 1'b1, 16'hB001, 1'b0, 2'b10);
        set_in(1, 1'b1, 16'hC001, 1'b1, 2'b10); settle();
        chk("ct_rdy_t", in_ready, 3'b000);
        next_cycle(); settle();
        chk("ct_rdy_t1", in_ready, 3'b001);
        next_cycle(); set_in(0, 1'b1, 16'hB002, 1'b1, 2'b10); settle();
        chk("ct_rdy_t2", in_ready, 3'b001);
        chk("ct_flit_t2", out_flit[47:32], 16'hB001);
        next_cycle(); set_in(0, 1'b0, 16'h0, 1'b0, 2'b00); settle();
        chk("ct_rdy_t3", in_ready, 3'b000);
        chk("ct_flit_t3", out_flit[47:32], 16'hB002);
        chk("ct_tail_t3", out_tail, 3'b100);
        next_cycle(); settle();
        chk("ct_rdy_t4", in_ready, 3'b010);
        next_cycle();
        set_in(0, 1'b1, 16'hD001, 1'b1, 2'b10);
        set_in(1, 1'b1, 16'hE001, 1'b1, 2'b10); settle();
        chk("ct_flit_t5", out_flit[47:32], 16'hC001);
        chk("ct_rdy_t5", in_ready, 3'b000);
        next_cycle(); settle();
        chk("ct_rr_rdy_t6", in_ready, 3'b001);
        next_cycle(); set_in(0, 1'b0, 16'h0, 1'b0, 2'b00); settle();
        chk("ct_rdy_t7", in_ready, 3'b000);
        chk("ct_flit_t7", out_flit[47:32], 16'hD001);
        next_cycle(); settle();
        chk("ct_rdy_t8", in_ready, 3'b010);
        next_cycle(); set_in(1, 1'b0, 16'h0, 1'b0, 2'b00); settle();
        chk("ct_flit_t9", out_flit[47:32], 16'hE001);
        chk("ct_ov_t9", out_valid, 3'b100);

        // Backpressure mid-packet on east
        do_reset();
        out_ready = 3'b111;
        set_in(0, 1'b1, 16'hF001, 1'b0, 2'b10); settle();
        next_cycle(); settle();
        chk("bp_rdy_t1", in_ready, 3'b001);
        next_cycle(); set_in(0, 1'b1, 16'hF002, 1'b0, 2'b10); settle();
        chk("bp_flit_t2", out_flit[47:32], 16'hF001);
        chk("bp_rdy_t2", in_ready, 3'b001);
        next_cycle(); set_in(0, 1'b1, 16'hF003, 1'b1, 2'b10); out_ready = 3'b011; settle();
        chk("bp_flit_t3", out_flit[47:32], 16'hF002);
        chk("bp_rdy_t3", in_ready, 3'b000);
        for (int c = 0; c < 2; c++) begin
            next_cycle(); settle();
            chk("bp_hold_flit", out_flit[47:32], 16'hF002);
            chk("bp_hold_rdy", in_ready, 3'b000);
            chk("bp_hold_ov", out_valid, 3'b100);
        end
        next_cycle(); out_ready = 3'b111; settle();
        chk("bp_rel_flit", out_flit[47:32], 16'hF002);
        chk("bp_rel_rdy", in_ready, 3'b001);
        next_cycle(); idle_in(); settle();
        chk("bp_last_flit", out_flit[47:32], 16'hF003);
        chk("bp_last_tail", out_tail, 3'b100);
        next_cycle(); settle();
        chk("bp_drain_ov", out_valid, 3'b000);

        // Illegal routes: input 1 port 11, then input 2 U-turn east
        do_reset();
        set_in(1, 1'b1, 16'h1111, 1'b1, 2'b11); settle();
        chk("il_err_t", err_bad_port, 1'b0);
        chk("il_rdy_t", in_ready, 3'b000);
        next_cycle();
        set_in(1, 1'b0, 16'h0, 1'b0, 2'b00);
        set_in(2, 1'b1, 16'h2222, 1'b1, 2'b10); settle();
        chk("il_err_t1", err_bad_port, 1'b1);
        chk("il_rdy_t1", in_ready, 3'b000);
        for (int c = 0; c < 3; c++) begin
            next_cycle(); settle();
            chk("il_hold_rdy", in_ready, 3'b000);
            chk("il_hold_err", err_bad_port, 1'b1);
            chk("il_hold_ov", out_valid, 3'b000);
        end
        do_reset(); settle();
        chk("il_err_cleared", err_bad_port, 1'b0);

        // Reset while output 1 (west) is locked and holding a flit
        out_ready = 3'b101;
        set_in(0, 1'b1, 16'h6001, 1'b0, 2'b01); settle();
        next_cycle(); settle();
        chk("rm_rdy_t1", in_ready, 3'b001);
        next_cycle(); set_in(0, 1'b1, 16'h6002, 1'b0, 2'b01); settle();
        chk("rm_ov_t2", out_valid, 3'b010);
        chk("rm_flit_t2", out_flit[31:16], 16'h6001);
        chk("rm_rdy_t2", in_ready, 3'b000);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        idle_in();
        out_ready = 3'b111;
        set_in(2, 1'b1, 16'h7001, 1'b1, 2'b01); settle();
        chk("rm_ov_after", out_valid, 3'b000);
        chk("rm_rdy_after", in_ready, 3'b000);
        next_cycle(); settle();
        chk("rm_new_rdy_t1", in_ready, 3'b100);
        next_cycle();
        set_in(2, 1'b0, 16'h0, 1'b0, 2'b00);
        set_in(0, 1'b1, 16'h8001, 1'b1, 2'b00); settle();
        chk("rm_new_ov_t2", out_valid, 3'b010);
        chk("rm_new_flit_t2", out_flit[31:16], 16'h7001);
        chk("rm_new_tail_t2", out_tail, 3'b010);

        // Local-to-local is a legal route
        next_cycle(); settle();
        chk("ll_rdy", in_ready, 3'b001);
        chk("ll_err", err_bad_port, 1'b0);
        next_cycle(); idle_in(); settle();
        chk("ll_ov", out_valid, 3'b001);
        chk("ll_flit", out_flit[15:0], 16'h8001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
